// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg
//   Shared RV32I register-file constants and types.
//   XLEN  : data width of one register
//   NREGS : number of architectural registers, x0 included
//   AW    : register index width
//   REG_ZERO : index of the hardwired-zero register
// -----------------------------------------------------------------------------
package rv32_pkg;
  localparam int XLEN     = 32;
  localparam int NREGS    = 32;
  localparam int AW       = 5;
  localparam int REG_ZERO = 0;

  typedef logic [XLEN-1:0] word_t;
  typedef logic [AW-1:0]   reg_idx_t;

  // An index can exceed the array only when NREGS < 2**AW.
  function automatic logic idx_in_range(input reg_idx_t idx);
    return ({{(32-AW){1'b0}}, idx} < 32'(NREGS));
  endfunction
endpackage

// File: rtl/register_file_if.sv
// -----------------------------------------------------------------------------
// register_file_if
//   Bus between the pipeline (writeback + decode) and the register file.
//   we, rd_addr, rd_data : write port, driven by writeback
//   rs1_addr, rs2_addr   : read indices
//   rs1_data             : read data to ALU operand A
//   rs2_data             : read data to operand-B mux data0
//   master : pipeline side, slave : register file side
// -----------------------------------------------------------------------------
interface register_file_if;
  import rv32_pkg::*;

  logic     we;
  reg_idx_t rd_addr;
  word_t    rd_data;
  reg_idx_t rs1_addr;
  reg_idx_t rs2_addr;
  word_t    rs1_data;
  word_t    rs2_data;

  modport master (
    output we, rd_addr, rd_data, rs1_addr, rs2_addr,
    input  rs1_data, rs2_data
  );

  modport slave (
    input  we, rd_addr, rd_data, rs1_addr, rs2_addr,
    output rs1_data, rs2_data
  );
endinterface

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
//   One read port of the register file: address decode, x0 masking,
//   write-to-read bypass and an optional output register.
//   clk, rst   : clock and synchronous active-high reset
//   i_regs     : storage array contents
//   i_rs_addr  : read index
//   i_we, i_rd_addr, i_rd_data : same-cycle write, used for bypass
//   o_rs_data  : read data
// Parameters
//   REG_READ : 0 combinational read, 1 registered read (1-cycle latency)
//   FWD      : 1 enables write-to-read bypass
// -----------------------------------------------------------------------------
module regfile_read_port
  import rv32_pkg::*;
#(
  parameter int REG_READ = 0,
  parameter int FWD      = 1
) (
  input  logic     clk,
  input  logic     rst,
  input  word_t    i_regs [NREGS],
  input  reg_idx_t i_rs_addr,
  input  logic     i_we,
  input  reg_idx_t i_rd_addr,
  input  word_t    i_rd_data,
  output word_t    o_rs_data
);

  logic  w_hit;
  word_t w_data;
  word_t r_data;

  // Bypass hit: a live write to the same non-zero, in-range register.
  always_comb begin
    w_hit = (FWD != 0) && i_we
            && (i_rd_addr != reg_idx_t'(REG_ZERO))
            && idx_in_range(i_rd_addr)
            && (i_rd_addr == i_rs_addr);
  end

  // Read mux: x0 and out-of-range indices read as zero, even under bypass.
  always_comb begin
    w_data = '0;
    if ((i_rs_addr == reg_idx_t'(REG_ZERO)) || !idx_in_range(i_rs_addr)) begin
      w_data = '0;
    end else if (w_hit) begin
      w_data = i_rd_data;
    end else begin
      w_data = i_regs[i_rs_addr];
    end
  end

  // Optional output register; captures the bypassed value at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else begin
      r_data <= w_data;
    end
  end

  // Select latency mode.
  always_comb begin
    if (REG_READ != 0) begin
      o_rs_data = r_data;
    end else begin
      o_rs_data = w_data;
    end
  end

endmodule

// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   RV32I integer register file, 32 x XLEN, two read ports, one write port.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears all registers
//   rf  : register_file_if slave (write port, two read ports)
// Parameters
//   REG_READ : 0 combinational read, 1 registered read (1-cycle latency)
//   FWD      : 1 enables write-to-read bypass
// -----------------------------------------------------------------------------
module register_file
  import rv32_pkg::*;
#(
  parameter int REG_READ = 0,
  parameter int FWD      = 1
) (
  input  logic           clk,
  input  logic           rst,
  register_file_if.slave rf
);

  word_t r_regs [NREGS];
  logic  w_wr_en;
  word_t w_rs1_data;
  word_t w_rs2_data;

  // Writes to x0 or past the end of the array are dropped.
  always_comb begin
    w_wr_en = rf.we
              && (rf.rd_addr != reg_idx_t'(REG_ZERO))
              && idx_in_range(rf.rd_addr);
  end

  // Storage array; reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[rf.rd_addr] <= rf.rd_data;
    end
  end

  regfile_read_port #(.REG_READ(REG_READ), .FWD(FWD)) u_rs1 (
    .clk       (clk),
    .rst       (rst),
    .i_regs    (r_regs),
    .i_rs_addr (rf.rs1_addr),
    .i_we      (rf.we),
    .i_rd_addr (rf.rd_addr),
    .i_rd_data (rf.rd_data),
    .o_rs_data (w_rs1_data)
  );

  regfile_read_port #(.REG_READ(REG_READ), .FWD(FWD)) u_rs2 (
    .clk       (clk),
    .rst       (rst),
    .i_regs    (r_regs),
    .i_rs_addr (rf.rs2_addr),
    .i_we      (rf.we),
    .i_rd_addr (rf.rd_addr),
    .i_rd_data (rf.rd_data),
    .o_rs_data (w_rs2_data)
  );

  // Drive the interface read data.
  always_comb begin
    rf.rs1_data = w_rs1_data;
    rf.rs2_data = w_rs2_data;
  end

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Drives one stimulus stream into four register files, one per
//   (REG_READ, FWD) combination, and checks them against an array model
//   every cycle plus hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_register_file;
  import rv32_pkg::*;

  logic     clk;
  logic     s_rst;
  logic     s_we;
  reg_idx_t s_rd;
  word_t    s_wd;
  reg_idx_t s_rs1;
  reg_idx_t s_rs2;
  logic     s_alusrc;
  word_t    s_imm;
  logic     chk_en;

  int n_checks = 0;
  int n_errors = 0;

  register_file_if if_c1 ();  // REG_READ=0 FWD=1
  register_file_if if_c0 ();  // REG_READ=0 FWD=0
  register_file_if if_r1 ();  // REG_READ=1 FWD=1
  register_file_if if_r0 ();  // REG_READ=1 FWD=0

  assign if_c1.we = s_we;  assign if_c1.rd_addr = s_rd;  assign if_c1.rd_data = s_wd;
  assign if_c1.rs1_addr = s_rs1;  assign if_c1.rs2_addr = s_rs2;
  assign if_c0.we = s_we;  assign if_c0.rd_addr = s_rd;  assign if_c0.rd_data = s_wd;
  assign if_c0.rs1_addr = s_rs1;  assign if_c0.rs2_addr = s_rs2;
  assign if_r1.we = s_we;  assign if_r1.rd_addr = s_rd;  assign if_r1.rd_data = s_wd;
  assign if_r1.rs1_addr = s_rs1;  assign if_r1.rs2_addr = s_rs2;
  assign if_r0.we = s_we;  assign if_r0.rd_addr = s_rd;  assign if_r0.rd_data = s_wd;
  assign if_r0.rs1_addr = s_rs1;  assign if_r0.rs2_addr = s_rs2;

  register_file #(.REG_READ(0), .FWD(1)) dut_c1 (.clk(clk), .rst(s_rst), .rf(if_c1));
  register_file #(.REG_READ(0), .FWD(0)) dut_c0 (.clk(clk), .rst(s_rst), .rf(if_c0));
  register_file #(.REG_READ(1), .FWD(1)) dut_r1 (.clk(clk), .rst(s_rst), .rf(if_r1));
  register_file #(.REG_READ(1), .FWD(0)) dut_r0 (.clk(clk), .rst(s_rst), .rf(if_r0));

  // ALU operand-B mux downstream of rs2_data.
  word_t mux_out;
  assign mux_out = s_alusrc ? s_imm : if_c1.rs2_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  word_t m_regs [32];
  word_t q_r1_1, q_r1_2, q_r0_1, q_r0_2;

  // Architectural value a read of 'a' sees right now.
  function automatic word_t m_read(input reg_idx_t a, input bit fwd);
    if (a == 5'd0) return 32'h0;
    if (fwd && s_we && (s_rd != 5'd0) && (s_rd == a)) return s_wd;
    return m_regs[a];
  endfunction

  // Model state update at the clock edge.
  always @(posedge clk) begin
    if (s_rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
      q_r1_1 <= 32'h0; q_r1_2 <= 32'h0;
      q_r0_1 <= 32'h0; q_r0_2 <= 32'h0;
    end else begin
      q_r1_1 <= m_read(s_rs1, 1'b1);
      q_r1_2 <= m_read(s_rs2, 1'b1);
      q_r0_1 <= m_read(s_rs1, 1'b0);
      q_r0_2 <= m_read(s_rs2, 1'b0);
      if (s_we && (s_rd != 5'd0)) m_regs[s_rd] <= s_wd;
    end
  end

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("c1_rs1", if_c1.rs1_data, m_read(s_rs1, 1'b1));
      chk("c1_rs2", if_c1.rs2_data, m_read(s_rs2, 1'b1));
      chk("c0_rs1", if_c0.rs1_data, m_read(s_rs1, 1'b0));
      chk("c0_rs2", if_c0.rs2_data, m_read(s_rs2, 1'b0));
      chk("r1_rs1", if_r1.rs1_data, q_r1_1);
      chk("r1_rs2", if_r1.rs2_data, q_r1_2);
      chk("r0_rs1", if_r0.rs1_data, q_r0_1);
      chk("r0_rs2", if_r0.rs2_data, q_r0_2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input reg_idx_t rd, input word_t wd,
                       input reg_idx_t a1, input reg_idx_t a2);
    s_we = we; s_rd = rd; s_wd = wd; s_rs1 = a1; s_rs2 = a2;
  endtask

  initial begin
    chk_en = 1'b0;
    s_rst = 1'b1; s_alusrc = 1'b0; s_imm = 32'hCAFE0000;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step();

    // 1: reset state
    s_rst = 1'b0;
    chk_en = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    @(negedge clk);
    chk("t1_c1_rs1", if_c1.rs1_data, 32'h0);
    chk("t1_c1_rs2", if_c1.rs2_data, 32'h0);
    chk("t1_r1_rs1", if_r1.rs1_data, 32'h0);
    chk("t1_r1_rs2", if_r1.rs2_data, 32'h0);

    // 2: write x5 then read it
    step();
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    @(negedge clk);
    chk("t2_c1_rs1", if_c1.rs1_data, 32'hDEADBEEF);
    chk("t2_c0_rs1", if_c0.rs1_data, 32'hDEADBEEF);
    chk("t2_r1_early", if_r1.rs1_data, 32'h0);
    step();
    @(negedge clk);
    chk("t2_r1_rs1", if_r1.rs1_data, 32'hDEADBEEF);
    chk("t2_r0_rs1", if_r0.rs1_data, 32'hDEADBEEF);

    // 3: writes to x0 are ignored, x0 reads zero even under bypass
    step();
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    @(negedge clk);
    chk("t3_c1_rs1_same", if_c1.rs1_data, 32'h0);
    chk("t3_c1_rs2_same", if_c1.rs2_data, 32'h0);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    chk("t3_c1_rs1_after", if_c1.rs1_data, 32'h0);
    chk("t3_r1_rs2_after", if_r1.rs2_data, 32'h0);

    // 4: bypass vs no bypass, both ports on the same address
    step();
    drive(1'b1, 5'd7, 32'h0BADF00D, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    @(negedge clk);
    chk("t4_c1_rs2_fwd", if_c1.rs2_data, 32'h12345678);
    chk("t4_c1_rs1_fwd", if_c1.rs1_data, 32'h12345678);
    chk("t4_c0_rs2_old", if_c0.rs2_data, 32'h0BADF00D);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    @(negedge clk);
    chk("t4_c0_rs2_new", if_c0.rs2_data, 32'h12345678);
    chk("t4_r1_rs2_cap", if_r1.rs2_data, 32'h12345678);
    chk("t4_r0_rs2_old", if_r0.rs2_data, 32'h0BADF00D);
    step();
    @(negedge clk);
    chk("t4_r0_rs2_new", if_r0.rs2_data, 32'h12345678);

    // 5: through the operand-B mux
    step();
    drive(1'b1, 5'd10, 32'h00000001, 5'd0, 5'd0);
    step();
    drive(1'b1, 5'd11, 32'hFFFFFFFE, 5'd0, 5'd10);
    @(negedge clk);
    chk("t5_mux_x10", mux_out, 32'h00000001);
    step();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd11);
    @(negedge clk);
    chk("t5_mux_x11", mux_out, 32'hFFFFFFFE);
    s_alusrc = 1'b1;
    #1;
    chk("t5_mux_imm", mux_out, 32'hCAFE0000);
    s_alusrc = 1'b0;

    // 6: reset discards a same-cycle write and clears stored values
    step();
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd0);
    step();
    s_rst = 1'b1;
    drive(1'b1, 5'd4, 32'h5A5A5A5A, 5'd3, 5'd4);
    step();
    s_rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
    @(negedge clk);
    chk("t6_c1_x3", if_c1.rs1_data, 32'h0);
    chk("t6_c1_x4", if_c1.rs2_data, 32'h0);
    chk("t6_r1_x3", if_r1.rs1_data, 32'h0);
    step();
    @(negedge clk);
    chk("t6_r0_x4", if_r0.rs2_data, 32'h0);

    // Mixed traffic checked by the model only.
    for (int k = 0; k < 60; k++) begin
      step();
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), word_t'($urandom),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    step();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
